// File: rtl/rng_arbiter.sv
// rng_arbiter: seeds an external 4-bit LFSR, waits out a warm-up period, then
// hands out rejection-sampled random values (0..MAX_VAL) to two requesters
// using round-robin arbitration. Grant, value and valid are one-cycle pulses.
// Optional statistics: define RNG_ARBITER_STATS_EN to add the reject_cnt
// output, which counts rejected draws (saturating at 255).
module rng_arbiter #(
  parameter int MAX_VAL = 9,
  parameter int WARMUP  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] seed,
  input  logic       seed_valid,
  input  logic [1:0] req,
  input  logic [3:0] lfsr_q,
  output logic       lfsr_load,
  output logic [3:0] lfsr_seed,
  output logic [1:0] gnt,
  output logic [3:0] rnd,
  output logic       rnd_valid,
  output logic       busy
`ifdef RNG_ARBITER_STATS_EN
  ,
  output logic [7:0] reject_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;

  localparam logic [31:0] MAX_U     = MAX_VAL;
  localparam logic [3:0]  WARM_LAST = 4'(WARMUP - 1);

  state_t     state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       ptr, ptr_nxt;
  logic [1:0] mreq, gnt_nxt;
  logic       in_range, capture, win;

  // A requester whose grant is showing this cycle is not eligible again yet.
  assign mreq     = req & ~gnt;
  assign in_range = ({28'd0, lfsr_q} <= MAX_U);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, warm-up count, arbitration decision.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    ptr_nxt   = ptr;
    gnt_nxt   = 2'b00;
    capture   = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (seed_valid) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // Reseed requests are dropped while the LFSR is being loaded.
        wcnt_nxt  = 4'd0;
        state_nxt = (WARMUP > 0) ? WARM : RUN;
      end
      WARM: begin
        if (seed_valid) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end else if (wcnt == WARM_LAST) begin
          wcnt_nxt  = 4'd0;
          state_nxt = RUN;
        end else begin
          wcnt_nxt  = wcnt + 4'd1;
        end
      end
      RUN: begin
        // Reseed beats a grant; pending requests simply wait it out.
        if (seed_valid) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end else if ((|mreq) && in_range) begin
          win     = (mreq == 2'b11) ? ptr : mreq[1];
          gnt_nxt = win ? 2'b10 : 2'b01;
          ptr_nxt = ~win;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt      <= 4'd0;
      ptr       <= 1'b0;
      lfsr_seed <= 4'd1;
      lfsr_load <= 1'b0;
      gnt       <= 2'b00;
      rnd       <= 4'h0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wcnt      <= wcnt_nxt;
      ptr       <= ptr_nxt;
      lfsr_load <= (state_nxt == LOAD);
      busy      <= (state_nxt == LOAD) || (state_nxt == WARM);
      gnt       <= gnt_nxt;
      rnd_valid <= |gnt_nxt;
      if (|gnt_nxt) rnd <= lfsr_q;
      // An all-zero seed would lock the LFSR up, so substitute 1.
      if (capture) lfsr_seed <= (seed == 4'd0) ? 4'd1 : seed;
    end
  end

`ifdef RNG_ARBITER_STATS_EN
  logic reject;
  assign reject = (state == RUN) && !seed_valid && (|mreq) && !in_range;

  // Saturating count of rejected draws; restarts with every seed load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      reject_cnt <= 8'd0;
    else if (state_nxt == LOAD)      reject_cnt <= 8'd0;
    else if (reject && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against an edge-counting behavioural model.
module tb_rng_arbiter;
  localparam int MAX_VAL = 9;
  localparam int WARMUP  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       seed_valid = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] lfsr_q = 4'h0;
  logic       lfsr_load;
  logic [3:0] lfsr_seed;
  logic [1:0] gnt;
  logic [3:0] rnd;
  logic       rnd_valid;
  logic       busy;
`ifdef RNG_ARBITER_STATS_EN
  logic [7:0] reject_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  logic check_en = 1'b0;

  rng_arbiter #(.MAX_VAL(MAX_VAL), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .seed(seed), .seed_valid(seed_valid),
    .req(req), .lfsr_q(lfsr_q), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .gnt(gnt), .rnd(rnd), .rnd_valid(rnd_valid), .busy(busy)
`ifdef RNG_ARBITER_STATS_EN
    , .reject_cnt(reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: 'since' counts clock edges since the last accepted seed capture
  // (-1 = never seeded). Edge 1 after capture is the load edge (reseed
  // ignored); grants are possible from edge 2+WARMUP onward.
  int         since = -1;
  int         k;
  int         m_rej = 0;
  logic [3:0] m_seed = 4'd1;
  logic [1:0] m_gnt = 2'b00;
  logic [3:0] m_rnd = 4'd0;
  logic       m_rv = 1'b0;
  logic       m_last = 1'b1;
  logic       w;
  logic [1:0] elig;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      since = -1; m_seed = 4'd1; m_gnt = 2'b00; m_rv = 1'b0; m_rnd = 4'd0;
      m_last = 1'b1; m_rej = 0;
    end else begin
      elig  = req & ~m_gnt;
      m_gnt = 2'b00;
      m_rv  = 1'b0;
      k = (since < 0) ? -1 : since + 1;
      if (seed_valid && k != 1) begin
        since  = 0;
        m_seed = (seed == 4'd0) ? 4'd1 : seed;
        m_rej  = 0;
      end else begin
        if (k >= 0) since = (k > 1000) ? 1000 : k;
        if (k >= 2 + WARMUP && elig != 2'b00) begin
          if (int'(lfsr_q) <= MAX_VAL) begin
            w      = (elig == 2'b11) ? ~m_last : elig[1];
            m_gnt  = w ? 2'b10 : 2'b01;
            m_rv   = 1'b1;
            m_rnd  = lfsr_q;
            m_last = w;
          end else if (m_rej < 255) begin
            m_rej++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("gnt", int'(gnt), int'(m_gnt));
      check("rnd_valid", int'(rnd_valid), int'(m_rv));
      if (m_rv) check("rnd", int'(rnd), int'(m_rnd));
      check("lfsr_load", int'(lfsr_load), int'(since == 0));
      check("busy", int'(busy), int'(since >= 0 && since <= WARMUP));
      check("lfsr_seed", int'(lfsr_seed), int'(m_seed));
`ifdef RNG_ARBITER_STATS_EN
      check("reject_cnt", int'(reject_cnt), m_rej);
`endif
    end
  end

  task automatic step(input logic sv, input logic [3:0] sd, input logic [1:0] rq,
                      input logic [3:0] q);
    seed_valid = sv; seed = sd; req = rq; lfsr_q = q;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_rnd", int'(rnd), 0);
    check("rst_rv", int'(rnd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_load", int'(lfsr_load), 0);
    check("rst_seed", int'(lfsr_seed), 1);
    reset = 1'b1;
    check_en = 1'b1;

    // Zero seed replaced by 1; load one cycle; busy four cycles.
    step(1, 4'h0, 2'b00, 4'h0);
    check("seed0_seed", int'(lfsr_seed), 1);
    check("seed0_load", int'(lfsr_load), 1);
    check("seed0_busy0", int'(busy), 1);
    step(0, 4'h0, 2'b00, 4'h0);
    check("seed0_load_off", int'(lfsr_load), 0);
    check("seed0_busy1", int'(busy), 1);
    step(0, 4'h0, 2'b00, 4'h0);
    check("seed0_busy2", int'(busy), 1);
    step(0, 4'h0, 2'b00, 4'h0);
    check("seed0_busy3", int'(busy), 1);
    step(0, 4'h0, 2'b00, 4'h0);
    check("seed0_run", int'(busy), 0);

    // Rejection sampling.
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h0, 2'b01, 4'hC);
      check("rej_gnt", int'(gnt), 0);
    end
    step(0, 4'h0, 2'b01, 4'h5);
    check("acc_gnt", int'(gnt), 1);
    check("acc_rnd", int'(rnd), 5);
    check("acc_rv", int'(rnd_valid), 1);
    step(0, 4'h0, 2'b00, 4'h5);
    check("acc_pulse", int'(rnd_valid), 0);

    // Sole requester 1 wins, pointer returns to requester 0.
    step(0, 4'h0, 2'b10, 4'h1);
    check("sole1_gnt", int'(gnt), 2);
    step(0, 4'h0, 2'b00, 4'h1);

    // Round-robin on consecutive cycles.
    step(0, 4'h0, 2'b11, 4'h3);
    check("rr_gnt0", int'(gnt), 1);
    check("rr_rnd0", int'(rnd), 3);
    step(0, 4'h0, 2'b11, 4'h7);
    check("rr_gnt1", int'(gnt), 2);
    check("rr_rnd1", int'(rnd), 7);
    step(0, 4'h0, 2'b00, 4'h7);
    check("rr_idle", int'(gnt), 0);

    // Boundary: 9 accepted, 10 rejected.
    step(0, 4'h0, 2'b01, 4'h9);
    check("max_gnt", int'(gnt), 1);
    check("max_rnd", int'(rnd), 9);
    step(0, 4'h0, 2'b00, 4'h9);
    step(0, 4'h0, 2'b11, 4'hA);
    check("over_gnt", int'(gnt), 0);
    step(0, 4'h0, 2'b00, 4'hA);

    // Reseed collides with a qualifying grant; reseed in LOAD ignored.
    step(1, 4'h6, 2'b10, 4'h2);
    check("col_gnt", int'(gnt), 0);
    check("col_load", int'(lfsr_load), 1);
    check("col_seed", int'(lfsr_seed), 6);
    step(1, 4'hB, 2'b10, 4'h2);
    check("ldign_seed", int'(lfsr_seed), 6);
    check("ldign_load", int'(lfsr_load), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h0, 2'b10, 4'h2);
      check("col_wait", int'(gnt), 0);
    end
    step(0, 4'h0, 2'b10, 4'h2);
    check("col_gnt_late", int'(gnt), 2);
    check("col_rnd_late", int'(rnd), 2);
    step(0, 4'h0, 2'b00, 4'h2);

    // Asynchronous reset while a grant is showing.
    step(0, 4'h0, 2'b10, 4'h4);
    check("pre_rst_gnt", int'(gnt), 2);
    #2 reset = 1'b0;
    #1;
    check("arst_gnt", int'(gnt), 0);
    check("arst_rnd", int'(rnd), 0);
    check("arst_rv", int'(rnd_valid), 0);
    check("arst_seed", int'(lfsr_seed), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h0, 2'b11, 4'h4);
      check("idle_nogrant", int'(gnt), 0);
    end
    step(1, 4'h3, 2'b11, 4'h4);
    check("rs_seed", int'(lfsr_seed), 3);
    for (int i = 0; i < 4; i++) begin
      step(0, 4'h0, 2'b11, 4'h4);
      check("rs_wait", int'(gnt), 0);
    end
    step(0, 4'h0, 2'b11, 4'h4);
    check("rs_gnt0", int'(gnt), 1);
    step(0, 4'h0, 2'b11, 4'h4);
    check("rs_gnt1", int'(gnt), 2);
    step(0, 4'h0, 2'b00, 4'h4);

`ifdef RNG_ARBITER_STATS_EN
    for (int i = 0; i < 300; i++) step(0, 4'h0, 2'b01, 4'hF);
    check("stat_sat", int'(reject_cnt), 255);
    step(1, 4'h5, 2'b00, 4'h0);
    check("stat_clr", int'(reject_cnt), 0);
`endif

    repeat (6) step(0, 4'h0, 2'b00, 4'h0);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter MAX_VAL, default 9: largest LFSR value accepted as a result; larger values are rejected (decimal 0-9 for seven-segment display).
REQ-002 Parameter WARMUP, default 3: free-running shift cycles after each seed load before results are issued; legal range 0-15.
REQ-003 Ports shall be:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- seed  in  4  seed value.
- seed_valid  in  1  single-cycle reseed request.
- req  in  2  per-requester random-number request, level, held until granted.
- lfsr_q  in  4  current LFSR state.
- lfsr_load  out  1  load strobe to LFSR; LFSR shifts when low.
- lfsr_seed  out  4  seed presented to LFSR.
- gnt  out  2  one-hot grant, one-cycle pulse.
- rnd  out  4  issued random value.
- rnd_valid  out  1  high exactly when gnt is nonzero.
- busy  out  1  high in LOAD and WARM.
REQ-004 The block shall have one clock, clk; reset shall be asynchronous and active-low.

Function
REQ-005 The FSM shall have states IDLE, LOAD, WARM and RUN.
REQ-006 IDLE: on seed_valid=1, capture seed into lfsr_seed and go to LOAD; otherwise stay.
REQ-007 Seed 4'b0000 shall be replaced by 4'b0001 on capture, preventing LFSR lock-up.
REQ-008 LOAD: lfsr_load=1 for exactly one cycle; next state WARM if WARMUP>0, else RUN.
REQ-009 WARM: a 4-bit counter counts WARMUP cycles with lfsr_load=0, then the FSM enters RUN.
REQ-010 RUN: lfsr_load=0. On each edge where the masked req is nonzero and lfsr_q<=MAX_VAL, the block registers:
- gnt: one-hot to the winner.
- rnd: lfsr_q.
- rnd_valid: 1.
All three are valid in the following cycle only.
REQ-011 When lfsr_q>MAX_VAL, no grant shall be issued that cycle; requests stay pending (rejection sampling).
REQ-012 Arbitration shall be round-robin. The priority pointer resets to requester 0 and moves to the other requester after each grant. A sole requester always wins.
REQ-013 During the cycle a requester's gnt bit is high, that requester's req bit shall be masked, so no double grant results from a late-dropping req.
REQ-014 Grants may issue on consecutive cycles to alternate requesters.
REQ-015 seed_valid in WARM or RUN shall recapture the seed and go to LOAD.
REQ-016 A seed_valid arriving in the same cycle as a qualifying grant condition shall win: no grant is issued and pending requests are preserved.
REQ-017 seed_valid in LOAD shall be ignored.
REQ-018 No grant shall issue in IDLE, LOAD or WARM; requests shall wait.
REQ-019 gnt, rnd, rnd_valid, lfsr_load and busy shall be registered outputs.

Reset
REQ-020 reset low shall asynchronously force:
- state IDLE.
- lfsr_seed=4'b0001.
- lfsr_load=0.
- gnt=2'b00, rnd=4'h0, rnd_valid=0, busy=0.
- priority pointer=0.
- warm-up counter=0.
REQ-021 reset asserted mid-grant shall clear gnt immediately; that grant is lost and the requester re-requests.
REQ-022 Deassertion of reset shall take effect at the next rising clk edge.

Configuration
REQ-023 With macro RNG_ARBITER_STATS_EN defined, the block shall add an output reject_cnt (8 bits). It increments on every RUN cycle with a nonzero masked req and lfsr_q>MAX_VAL, saturates at 255, and clears on reset or on LOAD entry.
REQ-024 Without RNG_ARBITER_STATS_EN, the reject_cnt port and its logic shall be absent; all other behaviour is identical.

Verification
REQ-025 Seeding: seed=4'h0 with seed_valid pulsed -> lfsr_seed=4'h1, lfsr_load high for one cycle, busy high for 4 cycles (WARMUP=3), then RUN.
REQ-026 Rejection: in RUN, req=01, lfsr_q=4'hC for 3 cycles then 4'h5 -> no grant for 3 cycles; then gnt=01, rnd=4'h5, rnd_valid=1 for one cycle.
REQ-027 Arbitration: req=11 held, lfsr_q=4'h3 then 4'h7 -> gnt=01 with rnd=3, then gnt=10 with rnd=7 on consecutive cycles, with no repeat grant to requester 0.
REQ-028 Reseed collision: seed_valid=1 together with req=10 and lfsr_q=4'h2 -> no grant and LOAD entered; grant to requester 1 issues after warm-up.
REQ-029 Reset: reset low while gnt=10 -> gnt=00, rnd=0, state IDLE within the same cycle; req held -> no grant until a new seed_valid and warm-up complete.
REQ-030 With RNG_ARBITER_STATS_EN: 300 rejected cycles -> reject_cnt=255; a reseed -> reject_cnt=0.
